// File: rtl/regfile_mp.sv
// Multi-ported register file: two combinational read ports, one write port, a pending-write scoreboard
// and a post-reset clear sequence. Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_mp #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ready,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    output logic [WIDTH-1:0] rs1_data,
    output logic [WIDTH-1:0] rs2_data,
    output logic             rs1_busy,
    output logic             rs2_busy,
    input  logic             we,
    input  logic [AW-1:0]    rd_addr,
    input  logic [WIDTH-1:0] rd_data,
    input  logic             alloc_valid,
    input  logic [AW-1:0]    alloc_addr
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_e           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [DEPTH-1:0] busy_q, busy_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;
    logic             wr_commit;
    logic             alloc_set;

    logic [AW-1:0]    rs_addr [2];
    logic [WIDTH-1:0] rs_data [2];
    logic             rs_busy [2];

    assign ready     = (state_q == READY);
    assign wr_commit = we && ready && (rd_addr != '0);
    assign alloc_set = alloc_valid && ready && (alloc_addr != '0);

    // The single array write port is shared between the clear walk and normal writes.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        unique case (state_q)
            CLEAR: begin
                mem_we = 1'b1;
                cnt_d  = cnt_q + AW'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (wr_commit) begin
                    mem_we    = 1'b1;
                    mem_waddr = rd_addr;
                    mem_wdata = rd_data;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // Set after clear so an allocate and a write to the same entry leave it busy.
    always_comb begin
        busy_d = busy_q;
        if (wr_commit) begin
            busy_d[rd_addr] = 1'b0;
        end
        if (alloc_set) begin
            busy_d[alloc_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= AW'(1);
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // NOTE: the array has no reset; the clear walk zeroes it instead, keeping it mappable to RAM.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign rs_addr[0] = rs1_addr;
    assign rs_addr[1] = rs2_addr;

    // Entry 0 is hardwired to zero and never busy; nothing is visible until the clear completes.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rs_data[p] = '0;
            rs_busy[p] = 1'b0;
            if (ready && (rs_addr[p] != '0)) begin
                rs_data[p] = mem_q[rs_addr[p]];
                rs_busy[p] = busy_q[rs_addr[p]];
            end
`ifdef REGFILE_BYPASS_EN
            if (wr_commit && (rd_addr == rs_addr[p])) begin
                rs_data[p] = rd_data;
                rs_busy[p] = alloc_valid && (alloc_addr == rs_addr[p]);
            end
`endif
        end
    end

    assign rs1_data = rs_data[0];
    assign rs2_data = rs_data[1];
    assign rs1_busy = rs_busy[0];
    assign rs2_busy = rs_busy[1];

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (WIDTH=32, DEPTH=32); follows REGFILE_BYPASS_EN when defined.
module tb_regfile_mp;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             ready;
    logic [AW-1:0]    rs1_addr, rs2_addr;
    logic [WIDTH-1:0] rs1_data, rs2_data;
    logic             rs1_busy, rs2_busy;
    logic             we;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             alloc_valid;
    logic [AW-1:0]    alloc_addr;

    int checks = 0;
    int errors = 0;

    regfile_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ready      (ready),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy),
        .we         (we),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .alloc_valid(alloc_valid),
        .alloc_addr (alloc_addr)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after a rising edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we          = 1'b0;
        rd_addr     = '0;
        rd_data     = '0;
        alloc_valid = 1'b0;
        alloc_addr  = '0;
    endtask

    // Counts edges until ready rises, dropping we/alloc as soon as it does; gives up after 100 edges.
    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
        idle();
        #1;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
        checks++;
        wait_ready(n);
        if (n !== 31) begin errors++; $display("FAIL reset_ready_edges got %0d exp 31", n); end
        checks++;
        for (int i = 0; i < DEPTH; i++) begin
            rs1_addr = AW'(i);
            rs2_addr = AW'(DEPTH - 1 - i);
            #1;
            if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
                errors++;
                $display("FAIL reset_clear entry %0d got %h/%h exp 0", i, rs1_data, rs2_data);
            end
            checks++;
            if (rs1_busy !== 1'b0) begin errors++; $display("FAIL reset_busy entry %0d got %b exp 0", i, rs1_busy); end
            checks++;
        end
    endtask

    task automatic test_bypass();
        we       = 1'b1;
        rd_addr  = 5'd5;
        rd_data  = 32'hDEADBEEF;
        rs1_addr = 5'd5;
        #1;
        if (rs1_data !== (BYP ? 32'hDEADBEEF : 32'h0)) begin
            errors++; $display("FAIL bypass_same_cycle got %h exp %h", rs1_data, BYP ? 32'hDEADBEEF : 32'h0);
        end
        checks++;
        tick();
        idle();
        #1;
        if (rs1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_next_cycle got %h exp deadbeef", rs1_data); end
        checks++;
    endtask

    task automatic test_zero_entry();
        we          = 1'b1;
        rd_addr     = 5'd0;
        rd_data     = 32'h12345678;
        alloc_valid = 1'b1;
        alloc_addr  = 5'd0;
        rs2_addr    = 5'd0;
        tick();
        idle();
        #1;
        if (rs2_data !== 32'h0) begin errors++; $display("FAIL zero_data got %h exp 0", rs2_data); end
        checks++;
        if (rs2_busy !== 1'b0) begin errors++; $display("FAIL zero_busy got %b exp 0", rs2_busy); end
        checks++;
    endtask

    task automatic test_scoreboard();
        alloc_valid = 1'b1;
        alloc_addr  = 5'd7;
        rs1_addr    = 5'd7;
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_alloc cycle %0d got %b exp 1", i, rs1_busy); end
            checks++;
        end
        // Write and allocate the same entry: set wins.
        we          = 1'b1;
        rd_addr     = 5'd7;
        rd_data     = 32'hAAAA0007;
        alloc_valid = 1'b1;
        alloc_addr  = 5'd7;
        #1;
        if (rs1_busy !== 1'b1 || rs1_data !== (BYP ? 32'hAAAA0007 : 32'h0)) begin
            errors++; $display("FAIL sb_setwin_cycle got %b/%h exp 1/%h", rs1_busy, rs1_data, BYP ? 32'hAAAA0007 : 32'h0);
        end
        checks++;
        tick();
        idle();
        #1;
        if (rs1_busy !== 1'b1 || rs1_data !== 32'hAAAA0007) begin
            errors++; $display("FAIL sb_setwin got %b/%h exp 1/aaaa0007", rs1_busy, rs1_data);
        end
        checks++;
        we      = 1'b1;
        rd_addr = 5'd7;
        rd_data = 32'hBBBB0007;
        #1;
        if (rs1_busy !== !BYP || rs1_data !== (BYP ? 32'hBBBB0007 : 32'hAAAA0007)) begin
            errors++; $display("FAIL sb_clear_cycle got %b/%h exp %b/%h", rs1_busy, rs1_data, !BYP, BYP ? 32'hBBBB0007 : 32'hAAAA0007);
        end
        checks++;
        tick();
        idle();
        #1;
        if (rs1_busy !== 1'b0 || rs1_data !== 32'hBBBB0007) begin
            errors++; $display("FAIL sb_clear got %b/%h exp 0/bbbb0007", rs1_busy, rs1_data);
        end
        checks++;
        // Write one entry while allocating another on the same edge.
        alloc_valid = 1'b1;
        alloc_addr  = 5'd9;
        tick();
        we          = 1'b1;
        rd_addr     = 5'd9;
        rd_data     = 32'h99990009;
        alloc_addr  = 5'd10;
        tick();
        idle();
        rs1_addr = 5'd9;
        rs2_addr = 5'd10;
        #1;
        if (rs1_busy !== 1'b0 || rs1_data !== 32'h99990009) begin
            errors++; $display("FAIL sb_split_write got %b/%h exp 0/99990009", rs1_busy, rs1_data);
        end
        checks++;
        if (rs2_busy !== 1'b1) begin errors++; $display("FAIL sb_split_alloc got %b exp 1", rs2_busy); end
        checks++;
    endtask

    task automatic test_reset_in_ready();
        int n;
        we          = 1'b1;
        rd_addr     = 5'd31;
        rd_data     = 32'h31313131;
        alloc_valid = 1'b1;
        alloc_addr  = 5'd3;
        tick();
        idle();
        rs1_addr = 5'd3;
        rs2_addr = 5'd31;
        #1;
        if (rs1_busy !== 1'b1 || rs2_data !== 32'h31313131) begin
            errors++; $display("FAIL rr_setup got %b/%h exp 1/31313131", rs1_busy, rs2_data);
        end
        checks++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        if (ready !== 1'b0 || rs1_busy !== 1'b0 || rs2_data !== 32'h0) begin
            errors++; $display("FAIL rr_after_rst got %b/%b/%h exp 0/0/0", ready, rs1_busy, rs2_data);
        end
        checks++;
        wait_ready(n);
        if (n !== 31) begin errors++; $display("FAIL rr_ready_edges got %0d exp 31", n); end
        checks++;
        if (rs1_busy !== 1'b0 || rs2_data !== 32'h0) begin
            errors++; $display("FAIL rr_cleared got %b/%h exp 0/0", rs1_busy, rs2_data);
        end
        checks++;
    endtask

    task automatic test_reset_mid_clear();
        int n;
        we      = 1'b1;
        rd_addr = 5'd4;
        rd_data = 32'h44444444;
        tick();
        idle();
        rs1_addr = 5'd4;
        #1;
        if (rs1_data !== 32'h44444444) begin errors++; $display("FAIL mc_setup got %h exp 44444444", rs1_data); end
        checks++;
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        we          = 1'b1;
        rd_addr     = 5'd4;
        rd_data     = 32'h0BAD0BAD;
        alloc_valid = 1'b1;
        alloc_addr  = 5'd4;
        // Nine edges take cnt from 1 to 10.
        repeat (9) tick();
        if (ready !== 1'b0 || rs1_data !== 32'h0) begin
            errors++; $display("FAIL mc_during_clear got %b/%h exp 0/0", ready, rs1_data);
        end
        checks++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_ready(n);
        if (n !== 31) begin errors++; $display("FAIL mc_ready_edges got %0d exp 31", n); end
        checks++;
        if (rs1_data !== 32'h0 || rs1_busy !== 1'b0) begin
            errors++; $display("FAIL mc_entry4 got %h/%b exp 0/0", rs1_data, rs1_busy);
        end
        checks++;
    endtask

    initial begin
        rst      = 1'b1;
        rs1_addr = '0;
        rs2_addr = '0;
        idle();
        test_reset();
        test_bypass();
        test_zero_entry();
        test_scoreboard();
        test_reset_in_ready();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
